rhd_cmd_sequencer: RTL and testbench
====================================

Name: rhd_cmd_sequencer

Overview:
Command sequencer directly upstream of the RHD SPI master. After reset it issues the RHD2000 init register writes and the ADC calibration. It then loops CONVERT commands over all amplifier channels, one word per SPI transaction, using the master's start/done handshake. Each returned 32-bit word is tagged with the channel it belongs to, accounting for the RHD 2-command result pipeline, and presented as a sample stream to the downstream packer.

Parameters:
NUM_CHANNELS, 32, CONVERT commands per frame (1..64)
INIT_LEN, 18, register writes in init table (package ROM entries 0..INIT_LEN-1)
CAL_DUMMIES, 9, dummy READ commands issued after CALIBRATE
PIPE_DEPTH, 2, RHD command-to-result latency in transactions (fixed 2, parameter for documentation/checks)

Ports:
clk  in  1  system clock (same clock as SPI master)
rst  in  1  synchronous reset, active-high
enable  in  1  run acquisition; sampled at frame boundaries
spi_start  out  1  one-cycle pulse to SPI master start
spi_cmd  out  16  command word to SPI master data_in; held stable from start until done falls
spi_done  in  1  SPI master done (held high ~17 clk by master)
spi_rx  in  32  SPI master data_out; [31:16] MISO A word, [15:0] MISO B word
init_done  out  1  high once init + calibration complete; cleared only by rst
sample_valid  out  1  one-cycle pulse, sample fields valid
sample_channel  out  6  channel index of sample
sample_a  out  16  MISO A result
sample_b  out  16  MISO B result
frame_start  out  1  one-cycle pulse with sample_valid of channel 0
frame_count  out  32  frames completed, wraps at 2^32

Behaviour:
- Reset: all outputs 0, state IDLE, command index 0, frame_count 0, init_done 0. rst mid-transaction abandons it. spi_start stays low; init reruns after rst.
- Command encodings: WRITE {2'b10,reg[5:0],data[7:0]}; READ {2'b11,reg[5:0],8'h00}; CONVERT {2'b00,ch[5:0],8'h00}; CALIBRATE 16'h5500. Dummy command = READ reg 40 (16'hE800).
- Transaction handshake (ISSUE/WAIT pair, shared by all phases):
  - ISSUE drives spi_cmd and pulses spi_start for exactly 1 cycle.
  - WAIT_HI waits for spi_done rising edge, registered from the previous-cycle spi_done. On that edge the cycle captures spi_rx.
  - WAIT_LO waits for spi_done=0. The next ISSUE occurs no earlier than the cycle after done falls.
  - Minimum gap between start pulses is therefore the master's full transaction + done hold.
- Phase FSM states: IDLE -> INIT -> CAL -> CAL_DUMMY -> RUN -> IDLE.
  - IDLE: waits for enable=1. Goes to INIT if init_done=0, else RUN.
  - INIT: INIT_LEN WRITE transactions from the package ROM, in order. Received data is discarded.
  - CAL: one CALIBRATE transaction.
  - CAL_DUMMY: CAL_DUMMIES dummy transactions. init_done is set in the cycle the last one's done falls.
  - RUN: a frame is NUM_CHANNELS+2 transactions. Index k < NUM_CHANNELS sends CONVERT(k); indices NUM_CHANNELS and NUM_CHANNELS+1 send dummies.
- Sample tagging:
  - The result captured at transaction index k belongs to the command at k-2.
  - For k>=2, the cycle after capture asserts sample_valid with sample_channel=k-2 and sample_a/b from spi_rx.
  - k=0 and k=1 produce no sample, since they carry results of the previous frame's dummies.
  - frame_start accompanies channel 0. frame_count increments with the sample of channel NUM_CHANNELS-1.
- Enable:
  - enable falling mid-frame lets the frame complete all NUM_CHANNELS+2 transactions, then the FSM goes to IDLE.
  - enable falling during INIT/CAL does not abort them; the FSM goes to IDLE after CAL_DUMMY.
  - enable rising again skips init and goes straight to RUN.
- spi_done already high at ISSUE (misbehaving master): no start is issued until spi_done=0.
- sample_* fields hold their last values when sample_valid=0.

Decomposition:
- Package rhd_pkg holds:
  - command opcode constants and encode functions (write/read/convert);
  - CALIBRATE and dummy constants;
  - the INIT_LEN-entry init ROM as a constant array of {reg, data};
  - the phase FSM state enum.
- One sub-module, rhd_spi_handshake, contains the ISSUE/WAIT_HI/WAIT_LO transaction engine. It has a req/cmd input, an ack output, and a captured rx output. It is reused by all phases.

Test Plan:
- rst then enable=1, with a master model whose done lasts 17 cycles: first 18 spi_cmd values equal the ROM writes (e.g. entry 0 = 16'h80DE), then 16'h5500, then 9×16'hE800; init_done rises after the 28th transaction; spi_start is never high for 2 consecutive cycles.
- RUN frame, with the model returning spi_rx={k,~k} at transaction k: first sample has channel 0 with sample_a=2; channel 31 arrives at k=33; 32 sample_valid pulses per frame; frame_start once; frame_count=1.
- Two consecutive frames: transactions k=0,1 of frame 2 produce no sample_valid; spi_cmd sequence is CONVERT 0..31, E800, E800 repeating.
- enable deasserted at channel 5 of frame: all 34 transactions still issued, then IDLE; re-enable goes straight to CONVERT(0) with no init writes.
- rst asserted mid-RUN during WAIT_HI: next cycle all outputs 0, init_done=0; after release with enable=1, init restarts at ROM entry 0.
- spi_done held high 40 cycles: no new spi_start until 1 cycle after it falls.

Source files
------------

// File: rtl/rhd_pkg.sv
// RHD2000 command encodings, init register table and sequencer phases.
// Shared by the command sequencer and its SPI transaction engine.
package rhd_pkg;

  localparam int INIT_LEN = 18;

  localparam logic [1:0] OP_CONVERT = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_DUMMY     = 16'hE800;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_INIT,
    PH_CAL,
    PH_CAL_DUMMY,
    PH_RUN
  } phase_e;

  // {reg[5:0], data[7:0]}
  typedef logic [13:0] rom_entry_t;

  localparam rom_entry_t INIT_ROM [INIT_LEN] = '{
    {6'd0,  8'hDE},
    {6'd1,  8'h02},
    {6'd2,  8'h04},
    {6'd3,  8'h00},
    {6'd4,  8'h16},
    {6'd5,  8'h00},
    {6'd6,  8'h00},
    {6'd7,  8'h00},
    {6'd8,  8'h16},
    {6'd9,  8'h17},
    {6'd10, 8'hA8},
    {6'd11, 8'h0A},
    {6'd12, 8'h11},
    {6'd13, 8'h00},
    {6'd14, 8'hFF},
    {6'd15, 8'hFF},
    {6'd16, 8'hFF},
    {6'd17, 8'hFF}
  };

  function automatic logic [15:0] enc_write(
    input logic [5:0] r,
    input logic [7:0] d
  );
    return {OP_WRITE, r, d};
  endfunction

  function automatic logic [15:0] enc_read(
    input logic [5:0] r
  );
    return {OP_READ, r, 8'h00};
  endfunction

  function automatic logic [15:0] enc_convert(
    input logic [5:0] ch
  );
    return {OP_CONVERT, ch, 8'h00};
  endfunction

endpackage

// File: rtl/rhd_spi_handshake.sv
// One SPI master transaction per request: issue, wait done rise, wait done fall.
// Shared by every sequencer phase.
module rhd_spi_handshake (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_cmd,
  input  logic        i_spi_done,
  input  logic [31:0] i_spi_rx,
  output logic        o_spi_start,
  output logic [15:0] o_spi_cmd,
  output logic        o_ack,
  output logic        o_cap,
  output logic [31:0] o_rx
);

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_ISSUE,
    HS_WAIT_HI,
    HS_WAIT_LO
  } hs_e;

  hs_e  r_state;
  logic r_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HS_IDLE;
      r_done_q    <= 1'b0;
      o_spi_start <= 1'b0;
      o_spi_cmd   <= 16'h0000;
      o_ack       <= 1'b0;
      o_cap       <= 1'b0;
      o_rx        <= 32'h0;
    end else begin
      r_done_q    <= i_spi_done;
      o_spi_start <= 1'b0;
      o_ack       <= 1'b0;
      o_cap       <= 1'b0;
      unique case (r_state)
        HS_IDLE: begin
          if (i_req) begin
            o_spi_cmd <= i_cmd;
            r_state   <= HS_ISSUE;
          end
        end
        // a master still holding done from before must release it first
        HS_ISSUE: begin
          if (!i_spi_done) begin
            o_spi_start <= 1'b1;
            r_state     <= HS_WAIT_HI;
          end
        end
        HS_WAIT_HI: begin
          if (i_spi_done && !r_done_q) begin
            o_rx    <= i_spi_rx;
            o_cap   <= 1'b1;
            r_state <= HS_WAIT_LO;
          end
        end
        HS_WAIT_LO: begin
          if (!i_spi_done) begin
            o_ack   <= 1'b1;
            r_state <= HS_IDLE;
          end
        end
        default: r_state <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rhd_cmd_sequencer.sv
// RHD2000 command sequencer: init writes, calibration, then CONVERT loop.
// Results are tagged with the channel issued two transactions earlier.
module rhd_cmd_sequencer
  import rhd_pkg::*;
#(
  parameter int NUM_CHANNELS = 32,
  parameter int CAL_DUMMIES  = 9,
  parameter int PIPE_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        spi_start,
  output logic [15:0] spi_cmd,
  input  logic        spi_done,
  input  logic [31:0] spi_rx,
  output logic        init_done,
  output logic        sample_valid,
  output logic [5:0]  sample_channel,
  output logic [15:0] sample_a,
  output logic [15:0] sample_b,
  output logic        frame_start,
  output logic [31:0] frame_count
);

  localparam int FRAME_LEN = NUM_CHANNELS + PIPE_DEPTH;

  phase_e      r_phase;
  logic [6:0]  r_idx;
  logic        r_busy;
  logic        r_req;

  logic        w_ack;
  logic        w_cap;
  logic [31:0] w_rx;
  logic [15:0] w_cmd;
  rom_entry_t  w_rom;
  logic        w_last_init;
  logic        w_last_cal;
  logic        w_last_dummy;
  logic        w_last_frame;
  logic        w_tagged;

  assign w_rom = INIT_ROM[r_idx[4:0]];

  always_comb begin
    w_cmd = CMD_DUMMY;
    unique case (r_phase)
      PH_INIT: w_cmd = enc_write(w_rom[13:8], w_rom[7:0]);
      PH_CAL:  w_cmd = CMD_CALIBRATE;
      PH_RUN: begin
        if (r_idx < 7'(NUM_CHANNELS))
          w_cmd = enc_convert(r_idx[5:0]);
      end
      default: w_cmd = CMD_DUMMY;
    endcase
  end

  assign w_last_init  = (r_phase == PH_INIT) &&
                        (r_idx == 7'(INIT_LEN - 1));
  assign w_last_cal   = (r_phase == PH_CAL);
  assign w_last_dummy = (r_phase == PH_CAL_DUMMY) &&
                        (r_idx == 7'(CAL_DUMMIES - 1));
  assign w_last_frame = (r_phase == PH_RUN) &&
                        (r_idx == 7'(FRAME_LEN - 1));
  // first PIPE_DEPTH results of a frame belong to the previous frame
  assign w_tagged     = w_cap && (r_phase == PH_RUN) &&
                        (r_idx >= 7'(PIPE_DEPTH));

  rhd_spi_handshake u_hs (
    .clk         (clk),
    .rst         (rst),
    .i_req       (r_req),
    .i_cmd       (w_cmd),
    .i_spi_done  (spi_done),
    .i_spi_rx    (spi_rx),
    .o_spi_start (spi_start),
    .o_spi_cmd   (spi_cmd),
    .o_ack       (w_ack),
    .o_cap       (w_cap),
    .o_rx        (w_rx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase        <= PH_IDLE;
      r_idx          <= 7'd0;
      r_busy         <= 1'b0;
      r_req          <= 1'b0;
      init_done      <= 1'b0;
      sample_valid   <= 1'b0;
      sample_channel <= 6'd0;
      sample_a       <= 16'h0;
      sample_b       <= 16'h0;
      frame_start    <= 1'b0;
      frame_count    <= 32'd0;
    end else begin
      r_req        <= 1'b0;
      sample_valid <= 1'b0;
      frame_start  <= 1'b0;

      if (w_tagged) begin
        sample_valid   <= 1'b1;
        sample_channel <= 6'(r_idx - 7'(PIPE_DEPTH));
        sample_a       <= w_rx[31:16];
        sample_b       <= w_rx[15:0];
        frame_start    <= (r_idx == 7'(PIPE_DEPTH));
        if (w_last_frame)
          frame_count <= frame_count + 32'd1;
      end

      unique case (r_phase)
        PH_IDLE: begin
          if (enable) begin
            r_phase <= init_done ? PH_RUN : PH_INIT;
            r_idx   <= 7'd0;
          end
        end
        default: begin
          if (!r_busy) begin
            r_req  <= 1'b1;
            r_busy <= 1'b1;
          end else if (w_ack) begin
            r_busy <= 1'b0;
            r_idx  <= r_idx + 7'd1;
            unique case (1'b1)
              w_last_init: begin
                r_phase <= PH_CAL;
                r_idx   <= 7'd0;
              end
              w_last_cal: begin
                r_phase <= PH_CAL_DUMMY;
                r_idx   <= 7'd0;
              end
              w_last_dummy: begin
                init_done <= 1'b1;
                r_phase   <= enable ? PH_RUN : PH_IDLE;
                r_idx     <= 7'd0;
              end
              w_last_frame: begin
                r_phase <= enable ? PH_RUN : PH_IDLE;
                r_idx   <= 7'd0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rhd_cmd_sequencer.sv
// Directed bench for rhd_cmd_sequencer with a behavioural SPI master.
// Master returns {k,~k} for frame transaction k.
module tb_rhd_cmd_sequencer;

  localparam int NCH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        spi_done = 1'b0;
  logic [31:0] spi_rx = 32'h0;
  logic        spi_start;
  logic [15:0] spi_cmd;
  logic        init_done;
  logic        sample_valid;
  logic [5:0]  sample_channel;
  logic [15:0] sample_a;
  logic [15:0] sample_b;
  logic        frame_start;
  logic [31:0] frame_count;

  always #5 clk = ~clk;

  rhd_cmd_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .spi_start      (spi_start),
    .spi_cmd        (spi_cmd),
    .spi_done       (spi_done),
    .spi_rx         (spi_rx),
    .init_done      (init_done),
    .sample_valid   (sample_valid),
    .sample_channel (sample_channel),
    .sample_a       (sample_a),
    .sample_b       (sample_b),
    .frame_start    (frame_start),
    .frame_count    (frame_count)
  );

  localparam logic [15:0] ROM_EXP [18] = '{
    16'h80DE, 16'h8102, 16'h8204, 16'h8300,
    16'h8416, 16'h8500, 16'h8600, 16'h8700,
    16'h8816, 16'h8917, 16'h8AA8, 16'h8B0A,
    16'h8C11, 16'h8D00, 16'h8EFF, 16'h8FFF,
    16'h90FF, 16'h91FF
  };

  int total = 0;
  int bad   = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int hold_len = 17;

  initial begin : master
    int cnt;
    int hl;
    bit busy;
    int last_k;
    logic [15:0] k;
    busy = 0; cnt = 0; hl = 17; last_k = -1; k = 16'hFFFF;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0;
        spi_done = 1'b0;
        last_k = -1;
      end else if (busy) begin
        cnt++;
        if (cnt == 3) begin
          spi_done = 1'b1;
          spi_rx = {k, ~k};
          hl = hold_len;
        end else if (cnt == 3 + hl) begin
          spi_done = 1'b0;
          busy = 0;
        end
      end else if (spi_start) begin
        busy = 1;
        cnt = 0;
        if (spi_cmd[15:14] == 2'b00)
          last_k = int'(spi_cmd[13:8]);
        else if (last_k == NCH - 1 || last_k == NCH)
          last_k++;
        else
          last_k = -1;
        k = 16'(last_k);
      end
    end
  end

  typedef struct {
    logic [31:0] ch;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] fs;
    logic [31:0] fc;
  } smp_t;

  logic [15:0] cmds[$];
  smp_t        smps[$];
  int cyc = 0;
  int dbl_start = 0;
  int start_in_done = 0;
  int last_fall = 0;
  int last_start = 0;
  logic prev_start = 1'b0;
  logic prev_done = 1'b0;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (spi_start) begin
        cmds.push_back(spi_cmd);
        last_start = cyc;
        if (prev_start) dbl_start++;
        if (spi_done) start_in_done++;
      end
      if (prev_done && !spi_done) last_fall = cyc;
      if (sample_valid)
        smps.push_back('{32'(sample_channel), 32'(sample_a),
                         32'(sample_b), 32'(frame_start),
                         frame_count});
      prev_start = spi_start;
      prev_done = spi_done;
    end
  end

  task automatic chk_frame(input string tag);
    logic [31:0] e;
    chk({tag, "_ncmd"}, 32'(cmds.size()), 34);
    for (int i = 0; i < 34; i++) begin
      e = (i < NCH) ? (32'(i) << 8) : 32'hE800;
      chk($sformatf("%s_cmd%0d", tag, i), 32'(cmds[i]), e);
    end
    chk({tag, "_nsmp"}, 32'(smps.size()), 32);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_ch%0d", tag, i), smps[i].ch, 32'(i));
    chk({tag, "_a0"}, smps[0].a, 32'h2);
    chk({tag, "_b0"}, smps[0].b, 32'hFFFD);
    chk({tag, "_fs0"}, smps[0].fs, 32'h1);
    chk({tag, "_a31"}, smps[31].a, 32'd33);
    chk({tag, "_b31"}, smps[31].b, 32'hFFDE);
  endtask

  initial begin : stim
    int fs_cnt;
    int s0;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start", 32'(spi_start), 0);
    chk("rst_cmd", 32'(spi_cmd), 0);
    chk("rst_initdone", 32'(init_done), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_fc", frame_count, 0);

    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
    chk("init_done", 32'(init_done), 1);
    chk("init_ncmd", 32'(cmds.size()), 28);
    for (int i = 0; i < 18; i++)
      chk($sformatf("rom%0d", i), 32'(cmds[i]), 32'(ROM_EXP[i]));
    chk("cal_cmd", 32'(cmds[18]), 32'h5500);
    for (int i = 19; i < 28; i++)
      chk($sformatf("dummy%0d", i), 32'(cmds[i]), 32'hE800);
    chk("init_nosmp", 32'(smps.size()), 0);

    cmds.delete();
    smps.delete();
    for (int i = 0; i < 2000 && frame_count < 1; i++) @(negedge clk);
    chk("f1_fc", frame_count, 1);
    chk_frame("f1");
    fs_cnt = 0;
    foreach (smps[i]) fs_cnt += int'(smps[i].fs);
    chk("f1_fs_cnt", 32'(fs_cnt), 1);
    chk("f1_fc31", smps[31].fc, 1);

    cmds.delete();
    smps.delete();
    for (int i = 0; i < 2000 && frame_count < 2; i++) @(negedge clk);
    chk("f2_fc", frame_count, 2);
    chk_frame("f2");

    cmds.delete();
    smps.delete();
    for (int i = 0; i < 2000 &&
         !(sample_valid && sample_channel == 6'd5); i++)
      @(negedge clk);
    chk("f3_ch5_seen", 32'(sample_channel), 5);
    enable = 1'b0;
    for (int i = 0; i < 2000 && frame_count < 3; i++) @(negedge clk);
    repeat (300) @(negedge clk);
    chk("f3_fc", frame_count, 3);
    chk_frame("f3");

    cmds.delete();
    enable = 1'b1;
    for (int i = 0; i < 200 && cmds.size() == 0; i++) @(negedge clk);
    chk("reen_n", 32'(cmds.size()), 1);
    chk("reen_cmd", 32'(cmds[0]), 32'h0000);
    chk("reen_initdone", 32'(init_done), 1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_start", 32'(spi_start), 0);
    chk("mrst_cmd", 32'(spi_cmd), 0);
    chk("mrst_initdone", 32'(init_done), 0);
    chk("mrst_fc", frame_count, 0);
    chk("mrst_valid", 32'(sample_valid), 0);
    chk("mrst_a", 32'(sample_a), 0);
    @(negedge clk);
    cmds.delete();
    rst = 1'b0;
    for (int i = 0; i < 200 && cmds.size() == 0; i++) @(negedge clk);
    chk("rerun_n", 32'(cmds.size()), 1);
    chk("rerun_cmd", 32'(cmds[0]), 32'h80DE);

    s0 = last_start;
    hold_len = 40;
    for (int i = 0; i < 400 && cmds.size() < 2; i++) @(negedge clk);
    hold_len = 17;
    chk("hold_n", 32'(cmds.size()), 2);
    chk("hold_cmd", 32'(cmds[1]), 32'h8102);
    chk("hold_gap", 32'(last_start > last_fall), 1);
    chk("hold_wait", 32'(last_start - s0 > 43), 1);

    chk("dbl_start", 32'(dbl_start), 0);
    chk("start_in_done", 32'(start_in_done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
